hi_xcorr_ssp_tx: RTL and testbench

HI_XCORR_SSP_TX -- requirements
Module: hi_xcorr_ssp_tx

---
 rtl/hi_ssp_pkg.sv | 33 +++
 rtl/ssp_word_fifo.sv | 65 ++++++
 rtl/hi_xcorr_ssp_tx.sv | 125 ++++++++++++
 tb/tb_hi_xcorr_ssp_tx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hi_ssp_pkg.sv
// Shared definitions for the correlator-to-ARM SSP transmitter.
package hi_ssp_pkg;

    // Serialized word: {corr_i, corr_q}, MSB first.
    localparam int WORD_W = 16;

    // clk_div encodings: half-period of ssp_clk in carrier cycles is 2^clk_div.
    localparam logic [1:0] CLK_DIV_2  = 2'b00;
    localparam logic [1:0] CLK_DIV_4  = 2'b01;
    localparam logic [1:0] CLK_DIV_8  = 2'b10;
    localparam logic [1:0] CLK_DIV_16 = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FRAME = 2'b01,
        SHIFT = 2'b10,
        GAP   = 2'b11
    } ssp_state_e;

    // Terminal value of the half-period cycle counter (H - 1).
    function automatic logic [2:0] half_max(input logic [1:0] div);
        logic [2:0] m;
        case (div)
            CLK_DIV_2:  m = 3'd0;
            CLK_DIV_4:  m = 3'd1;
            CLK_DIV_8:  m = 3'd3;
            CLK_DIV_16: m = 3'd7;
            default:    m = 3'd0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ssp_word_fifo.sv
// Single-clock word FIFO with registered level and full/empty flags.
// A push while full is only honoured when a pop happens in the same cycle.
module ssp_word_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [AW:0]   level_nxt;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        level_nxt = level;
        if (do_push && !do_pop) begin
            level_nxt = level + 1'b1;
        end else if (!do_push && do_pop) begin
            level_nxt = level - 1'b1;
        end
    end

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            full  <= (level_nxt == FULL_LVL);
            empty <= (level_nxt == '0);
        end
    end

endmodule

// File: rtl/hi_xcorr_ssp_tx.sv
// Buffers correlator I/Q byte pairs and serializes them to the ARM over an
// SSP-style link (frame marker, then 16 bits MSB first, then a quiet gap).
// corr_valid is a one-cycle strobe with no back-pressure: a word arriving
// while the FIFO is full and not being popped is dropped and flagged.
module hi_xcorr_ssp_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int WORD_W     = hi_ssp_pkg::WORD_W
) (
    input  logic                         ck_1356meg,
    input  logic                         rst_n,
    input  logic                         corr_valid,
    input  logic [7:0]                   corr_i,
    input  logic [7:0]                   corr_q,
    input  logic [1:0]                   clk_div,
    output logic                         ssp_clk,
    output logic                         ssp_din,
    output logic                         ssp_frame,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overflow,
    output logic [1:0]                   fsm_state
);
    import hi_ssp_pkg::*;

    localparam int HALF_W = $clog2(2 * WORD_W);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * WORD_W - 1);
    localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(1);

    ssp_state_e         state;
    logic [WORD_W-1:0]  shreg;
    logic [1:0]         div_lat;
    logic [2:0]         cyc_cnt;
    logic [HALF_W-1:0]  half_cnt;
    logic               half_end;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [WORD_W-1:0]  fifo_rd_data;

    // The FIFO head is consumed only from IDLE, which is what yields the
    // single IDLE cycle between back-to-back words.
    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign fifo_push = corr_valid && (!fifo_full || fifo_pop);
    assign half_end  = (cyc_cnt == half_max(div_lat));
    assign fsm_state = state;

    ssp_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clk     (ck_1356meg),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data ({corr_i, corr_q}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (corr_valid && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

    // Transmit FSM. half_cnt counts ssp_clk half-periods within a state; in
    // SHIFT its LSB is the ssp_clk phase and the shift happens after each
    // high phase. Serial outputs are registered from the current state, so
    // the pins trail the state by one carrier cycle.
    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            div_lat   <= CLK_DIV_2;
            cyc_cnt   <= '0;
            half_cnt  <= '0;
            ssp_clk   <= 1'b0;
            ssp_din   <= 1'b0;
            ssp_frame <= 1'b0;
        end else begin
            ssp_frame <= (state == FRAME);
            ssp_clk   <= (state == SHIFT) && half_cnt[0];
            ssp_din   <= ((state == FRAME) || (state == SHIFT)) ? shreg[WORD_W-1] : 1'b0;

            if (state == IDLE) begin
                if (!fifo_empty) begin
                    shreg    <= fifo_rd_data;
                    div_lat  <= clk_div;
                    cyc_cnt  <= '0;
                    half_cnt <= '0;
                    state    <= FRAME;
                end
            end else if (!half_end) begin
                cyc_cnt <= cyc_cnt + 3'd1;
            end else begin
                cyc_cnt  <= '0;
                half_cnt <= half_cnt + 1'b1;
                if (state == FRAME && half_cnt == HALF_ONE) begin
                    state    <= SHIFT;
                    half_cnt <= '0;
                end
                if (state == SHIFT) begin
                    if (half_cnt[0]) begin
                        shreg <= {shreg[WORD_W-2:0], 1'b0};
                    end
                    if (half_cnt == HALF_LAST) begin
                        state    <= GAP;
                        half_cnt <= '0;
                    end
                end
                if (state == GAP && half_cnt == HALF_ONE) begin
                    state    <= IDLE;
                    half_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hi_xcorr_ssp_tx.sv
// Bench for hi_xcorr_ssp_tx: table of single-word vectors plus directed
// sequences for burst buffering, full-with-pop, overflow, clk_div change
// and mid-word reset. A monitor rebuilds each word from the pins and checks
// the whole waveform against a per-cycle model.
`timescale 1ns/1ps
module tb_hi_xcorr_ssp_tx;
    import hi_ssp_pkg::*;

    logic       ck_1356meg = 1'b0;
    logic       rst_n;
    logic       corr_valid;
    logic [7:0] corr_i;
    logic [7:0] corr_q;
    logic [1:0] clk_div;
    logic       ssp_clk;
    logic       ssp_din;
    logic       ssp_frame;
    logic [2:0] fifo_level;
    logic       overflow;
    logic [1:0] fsm_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Scoreboard entries: {log2(H), word}.
    logic [17:0] exp_q[$];
    int          rise_q[$];
    logic        mon_ignore = 1'b0;
    logic        mon_busy   = 1'b0;
    logic        mon_prev   = 1'b0;

    typedef struct {
        logic [7:0]  ci;
        logic [7:0]  cq;
        logic [1:0]  div;
        logic [15:0] word;
    } vec_t;
    vec_t vecs[4];

    hi_xcorr_ssp_tx #(.FIFO_DEPTH(4), .WORD_W(16)) dut (
        .ck_1356meg (ck_1356meg),
        .rst_n      (rst_n),
        .corr_valid (corr_valid),
        .corr_i     (corr_i),
        .corr_q     (corr_q),
        .clk_div    (clk_div),
        .ssp_clk    (ssp_clk),
        .ssp_din    (ssp_din),
        .ssp_frame  (ssp_frame),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock / reset block ----------------
    always #5 ck_1356meg = ~ck_1356meg;
    always @(posedge ck_1356meg) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] w, input logic [1:0] hl);
        exp_q.push_back({hl, w});
    endtask

    // Caller is at a falling edge; the strobe is sampled on the next rising edge.
    task automatic strobe(input logic [7:0] ci, input logic [7:0] cq);
        corr_i     = ci;
        corr_q     = cq;
        corr_valid = 1'b1;
        @(negedge ck_1356meg);
        corr_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy || fsm_state != IDLE || fifo_level != 3'd0) && n < 3000) begin
            @(negedge ck_1356meg);
            n++;
        end
        check({name, "_drain"}, 32'(n < 3000), 1);
    endtask

    // Samples 36H cycles starting at the current (frame-rise) sample.
    task automatic check_word(input logic [15:0] w, input int h);
        int          errs;
        int          nbits;
        int          r0;
        int          r1;
        logic [15:0] got;
        logic        pclk;
        logic        ef;
        logic        ec;
        logic        ed;
        errs = 0; nbits = 0; r0 = -1; r1 = -1; got = '0; pclk = 1'b0;
        for (int idx = 0; idx < 36 * h; idx++) begin
            if (idx > 0) @(negedge ck_1356meg);
            ef = (idx < 2 * h);
            ec = (idx >= 2 * h && idx < 34 * h) ? (((idx - 2 * h) / h) % 2 == 1) : 1'b0;
            if (idx < 2 * h)       ed = w[15];
            else if (idx < 34 * h) ed = w[15 - (idx - 2 * h) / (2 * h)];
            else                   ed = 1'b0;
            if (ssp_frame !== ef || ssp_clk !== ec || ssp_din !== ed) errs++;
            if (ssp_clk === 1'b1 && pclk === 1'b0) begin
                got = {got[14:0], ssp_din};
                nbits++;
                if (r0 < 0) r0 = idx;
                else if (r1 < 0) r1 = idx;
            end
            pclk = ssp_clk;
        end
        check("word_bits", 32'(got), 32'(w));
        check("bit_count", nbits, 16);
        check("wave_shape_errs", errs, 0);
        check("clk_period", r1 - r0, 2 * h);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [17:0] ent;
        forever begin
            @(negedge ck_1356meg);
            if (rst_n === 1'b1 && ssp_frame === 1'b1 && mon_prev === 1'b0 && !mon_ignore) begin
                mon_busy = 1'b1;
                rise_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    ent = exp_q.pop_front();
                    check_word(ent[15:0], 1 << ent[17:16]);
                end
                mon_busy = 1'b0;
            end
            mon_prev = ssp_frame;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        int h;
        int n;
        int quiet;

        vecs[0] = '{ci: 8'hA5, cq: 8'h3C, div: 2'b00, word: 16'hA53C};
        vecs[1] = '{ci: 8'h80, cq: 8'h01, div: 2'b11, word: 16'h8001};
        vecs[2] = '{ci: 8'hFF, cq: 8'h00, div: 2'b01, word: 16'hFF00};
        vecs[3] = '{ci: 8'h12, cq: 8'h34, div: 2'b10, word: 16'h1234};

        rst_n = 1'b0; corr_valid = 1'b1; corr_i = 8'hEE; corr_q = 8'hEE; clk_div = 2'b00;
        repeat (3) @(negedge ck_1356meg);
        check("rst_ssp_clk", 32'(ssp_clk), 0);
        check("rst_ssp_din", 32'(ssp_din), 0);
        check("rst_ssp_frame", 32'(ssp_frame), 0);
        check("rst_level_valid_ignored", 32'(fifo_level), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        corr_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge ck_1356meg);

        // Table of isolated words at each rate.
        for (int v = 0; v < 4; v++) begin
            h = 1 << vecs[v].div;
            clk_div = vecs[v].div;
            rise_q.delete();
            push_exp(vecs[v].word, vecs[v].div);
            strobe(vecs[v].ci, vecs[v].cq);
            c0 = cyc;
            check($sformatf("v%0d_level_after_e0", v), 32'(fifo_level), 1);
            repeat (2 + 36 * h + 1) @(negedge ck_1356meg);
            check($sformatf("v%0d_idle_after_word", v), 32'(fsm_state), 32'(IDLE));
            check($sformatf("v%0d_quiet_after_word", v), 32'({ssp_frame, ssp_clk, ssp_din}), 0);
            check($sformatf("v%0d_frame_latency", v), (rise_q.size() == 1) ? rise_q[0] - c0 : -1, 2);
            wait_drain($sformatf("v%0d", v));
        end

        // Five consecutive strobes, then a strobe on the exact pop cycle while full.
        clk_div = 2'b00;
        rise_q.delete();
        for (int k = 0; k < 5; k++) begin
            corr_i = 8'(8'h10 + k);
            corr_q = 8'(8'hC0 + k);
            corr_valid = 1'b1;
            push_exp({corr_i, corr_q}, 2'b00);
            @(negedge ck_1356meg);
        end
        corr_valid = 1'b0;
        check("burst_level_peak", 32'(fifo_level), 4);
        check("burst_no_overflow", 32'(overflow), 0);
        n = 0;
        while (fsm_state != IDLE && n < 100) begin
            @(negedge ck_1356meg);
            n++;
        end
        check("burst_reach_idle", 32'(n < 100), 1);
        check("burst_level_at_pop", 32'(fifo_level), 4);
        push_exp(16'h5AE7, 2'b00);
        strobe(8'h5A, 8'hE7);
        check("full_pop_level", 32'(fifo_level), 4);
        check("full_pop_no_overflow", 32'(overflow), 0);
        wait_drain("burst");
        check("burst_frames", rise_q.size(), 6);
        for (int k = 1; k < rise_q.size(); k++) begin
            check($sformatf("burst_gap%0d", k), rise_q[k] - rise_q[k-1], 37);
        end

        // Fill during a transfer, then one more strobe with no pop.
        push_exp(16'h2143, 2'b00);
        strobe(8'h21, 8'h43);
        for (int k = 0; k < 4; k++) begin
            corr_i = 8'(8'h30 + k);
            corr_q = 8'(8'h70 + k);
            corr_valid = 1'b1;
            push_exp({corr_i, corr_q}, 2'b00);
            @(negedge ck_1356meg);
        end
        corr_i = 8'hDE; corr_q = 8'hAD; corr_valid = 1'b1;
        @(negedge ck_1356meg);
        corr_valid = 1'b0;
        check("drop_level", 32'(fifo_level), 4);
        check("drop_overflow", 32'(overflow), 1);
        wait_drain("drop");
        check("overflow_sticky", 32'(overflow), 1);
        push_exp(16'h6699, 2'b00);
        strobe(8'h66, 8'h99);
        wait_drain("after_drop");
        check("overflow_still_set", 32'(overflow), 1);

        // clk_div change mid-word only affects the next word.
        clk_div = 2'b00;
        push_exp(16'hC35A, 2'b00);
        strobe(8'hC3, 8'h5A);
        n = 0;
        while (fsm_state != SHIFT && n < 50) begin
            @(negedge ck_1356meg);
            n++;
        end
        check("div_reach_shift", 32'(n < 50), 1);
        clk_div = 2'b10;
        push_exp(16'h0FF0, 2'b10);
        strobe(8'h0F, 8'hF0);
        wait_drain("div_change");

        // Reset in the middle of bit 7 with another word queued.
        clk_div = 2'b00;
        mon_ignore = 1'b1;
        strobe(8'h01, 8'h80);
        n = 0;
        while (ssp_frame !== 1'b1 && n < 20) begin
            @(negedge ck_1356meg);
            n++;
        end
        check("rst_test_frame_seen", 32'(n < 20), 1);
        strobe(8'h77, 8'h77);
        repeat (17) @(negedge ck_1356meg);
        check("pre_reset_din_bit7", 32'(ssp_din), 1);
        check("pre_reset_state", 32'(fsm_state), 32'(SHIFT));
        check("pre_reset_level", 32'(fifo_level), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", 32'({ssp_frame, ssp_clk, ssp_din}), 0);
        check("mid_rst_level", 32'(fifo_level), 0);
        check("mid_rst_overflow", 32'(overflow), 0);
        check("mid_rst_state", 32'(fsm_state), 32'(IDLE));
        @(negedge ck_1356meg);
        @(negedge ck_1356meg);
        rst_n = 1'b1;
        quiet = 0;
        repeat (40) begin
            @(negedge ck_1356meg);
            if (ssp_clk !== 1'b0 || ssp_frame !== 1'b0 || ssp_din !== 1'b0) quiet++;
        end
        check("post_rst_quiet", quiet, 0);
        check("post_rst_level", 32'(fifo_level), 0);
        mon_ignore = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
